alu: RTL and testbench

Parameterized integer ALU for the RV32 core's execute stage. It combines operands `i_a` and `i_b` under a 5-bit operation select and presents the result one clock later from an output register. It covers RV32I arithmetic, logic, shift and compare operations, branch-compare predicates, and the RV32M multiply family.

---
 rtl/alu.sv | 107 ++++++++++
 tb/tb_alu.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Integer ALU for the RV32 execute stage: RV32I arithmetic/logic/shift/compare,
// branch predicates and the RV32M multiply family, with one registered output stage.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [4:0]       i_op,
    output logic [WIDTH-1:0] o_result
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_PASSB  = 5'd10;
    localparam logic [4:0] OP_EQ     = 5'd11;
    localparam logic [4:0] OP_NE     = 5'd12;
    localparam logic [4:0] OP_GE     = 5'd13;
    localparam logic [4:0] OP_GEU    = 5'd14;
    localparam logic [4:0] OP_MUL    = 5'd15;
    localparam logic [4:0] OP_MULH   = 5'd16;
    localparam logic [4:0] OP_MULHSU = 5'd17;
    localparam logic [4:0] OP_MULHU  = 5'd18;
    localparam logic [4:0] OP_ADD4   = 5'd19;

    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    logic [SHW-1:0]     shamt;
    logic               lt_s;
    logic               lt_u;
    logic               eq;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   result_d;
    logic [WIDTH-1:0]   result_q;

    assign shamt = i_b[SHW-1:0];
    assign lt_s  = $signed(i_a) < $signed(i_b);
    assign lt_u  = i_a < i_b;
    assign eq    = i_a == i_b;

    // Extend operands to 2*WIDTH (sign or zero per op) so one truncated product
    // serves every multiply flavour; the low half is identical for all of them.
    always_comb begin
        a_ext = {{WIDTH{1'b0}}, i_a};
        b_ext = {{WIDTH{1'b0}}, i_b};
        if (i_op == OP_MULH || i_op == OP_MULHSU) begin
            a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
        end
        if (i_op == OP_MULH) begin
            b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};
        end
        prod = a_ext * b_ext;
    end

    // Next-result selection; reserved encodings fall through to zero.
    always_comb begin
        result_d = '0;
        case (i_op)
            OP_ADD:    result_d = i_a + i_b;
            OP_SUB:    result_d = i_a - i_b;
            OP_AND:    result_d = i_a & i_b;
            OP_OR:     result_d = i_a | i_b;
            OP_XOR:    result_d = i_a ^ i_b;
            OP_SLL:    result_d = i_a << shamt;
            OP_SRL:    result_d = i_a >> shamt;
            OP_SRA:    result_d = $unsigned($signed(i_a) >>> shamt);
            OP_SLT:    result_d = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU:   result_d = {{(WIDTH-1){1'b0}}, lt_u};
            OP_PASSB:  result_d = i_b;
            OP_EQ:     result_d = {{(WIDTH-1){1'b0}}, eq};
            OP_NE:     result_d = {{(WIDTH-1){1'b0}}, ~eq};
            OP_GE:     result_d = {{(WIDTH-1){1'b0}}, ~lt_s};
            OP_GEU:    result_d = {{(WIDTH-1){1'b0}}, ~lt_u};
            OP_MUL:    result_d = prod[WIDTH-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  result_d = prod[2*WIDTH-1:WIDTH];
            OP_ADD4:   result_d = i_a + FOUR;
            default:   result_d = '0;
        endcase
    end

    // Output register: captures every cycle, cleared immediately by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign o_result = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: reset behaviour, every op class, boundaries, pipelining.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] result;

    int          checks;
    int          errors;
    logic [31:0] prev_exp;

    alu #(.WIDTH(32)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_a      (a),
        .i_b      (b),
        .i_op     (op),
        .o_result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %s = %08h", tag, obs);
        end
    endtask

    // Drive one operation at the falling edge, confirm the output holds the previous
    // value between edges, then check the new result just after the next rising edge.
    task automatic apply(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] opv, input logic [31:0] exp);
        @(negedge clk);
        a  = av;
        b  = bv;
        op = opv;
        #1;
        check_eq({tag, "_hold"}, result, prev_exp);
        @(posedge clk);
        #1;
        check_eq(tag, result, exp);
        prev_exp = exp;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        prev_exp = 32'd0;
        rst_n    = 1'b1;
        a        = 32'd5;
        b        = 32'd7;
        op       = 5'd0;

        // Reset takes effect without a clock edge.
        #1 rst_n = 1'b0;
        #1;
        check_eq("reset_async", result, 32'd0);
        @(posedge clk);
        #1;
        check_eq("reset_held", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("reset_release_hold", result, 32'd0);
        @(posedge clk);
        #1;
        check_eq("first_capture", result, 32'd12);
        prev_exp = 32'd12;

        // Arithmetic wrap
        apply("add_wrap",  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000);
        apply("sub_wrap",  32'h00000000, 32'h00000001, 5'd1,  32'hFFFFFFFF);
        apply("add4_wrap", 32'hFFFFFFFE, 32'h12345678, 5'd19, 32'h00000002);

        // Logic
        apply("and", 32'hF0F01234, 32'h0FF0FF00, 5'd2, 32'h00F01200);
        apply("or",  32'hF0F01234, 32'h0FF0FF00, 5'd3, 32'hFFF0FF34);
        apply("xor", 32'hF0F01234, 32'h0FF0FF00, 5'd4, 32'hFF00ED34);

        // Shifts: upper bits of b ignored
        apply("sll",     32'h80000000, 32'h00000021, 5'd5, 32'h00000000);
        apply("srl",     32'h80000000, 32'h00000021, 5'd6, 32'h40000000);
        apply("sra",     32'h80000000, 32'h00000021, 5'd7, 32'hC0000000);
        apply("sra_pos", 32'h40000000, 32'hFFFFFFE4, 5'd7, 32'h04000000);
        apply("sll_31",  32'h00000001, 32'h0000001F, 5'd5, 32'h80000000);

        // Compares with a=-1, b=1
        apply("slt",   32'hFFFFFFFF, 32'h00000001, 5'd8,  32'h00000001);
        apply("sltu",  32'hFFFFFFFF, 32'h00000001, 5'd9,  32'h00000000);
        apply("ge",    32'hFFFFFFFF, 32'h00000001, 5'd13, 32'h00000000);
        apply("geu",   32'hFFFFFFFF, 32'h00000001, 5'd14, 32'h00000001);
        apply("eq",    32'hFFFFFFFF, 32'h00000001, 5'd11, 32'h00000000);
        apply("ne",    32'hFFFFFFFF, 32'h00000001, 5'd12, 32'h00000001);
        apply("passb", 32'hFFFFFFFF, 32'h00000001, 5'd10, 32'h00000001);
        apply("eq_same",  32'hDEADBEEF, 32'hDEADBEEF, 5'd11, 32'h00000001);
        apply("ge_same",  32'hDEADBEEF, 32'hDEADBEEF, 5'd13, 32'h00000001);
        apply("slt_same", 32'hDEADBEEF, 32'hDEADBEEF, 5'd8,  32'h00000000);

        // Multiply with a=-2, b=3
        apply("mul",    32'hFFFFFFFE, 32'h00000003, 5'd15, 32'hFFFFFFFA);
        apply("mulh",   32'hFFFFFFFE, 32'h00000003, 5'd16, 32'hFFFFFFFF);
        apply("mulhu",  32'hFFFFFFFE, 32'h00000003, 5'd18, 32'h00000002);
        apply("mulhsu", 32'hFFFFFFFE, 32'h00000003, 5'd17, 32'hFFFFFFFF);
        apply("mulhu_max",  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd18, 32'hFFFFFFFE);
        apply("mulh_max",   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16, 32'h00000000);
        apply("mulhsu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 32'hFFFFFFFF);
        apply("mulh_min",   32'h80000000, 32'h80000000, 5'd16, 32'h40000000);

        // Back-to-back pipelining and reserved encodings
        apply("pipe_add",  32'h00000003, 32'h00000004, 5'd0,  32'h00000007);
        apply("pipe_xor",  32'h000000FF, 32'h0000000F, 5'd4,  32'h000000F0);
        apply("pipe_rsv",  32'h000000FF, 32'h0000000F, 5'd25, 32'h00000000);
        apply("rsv_20",    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, 32'h00000000);
        apply("rsv_31",    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'h00000000);
        apply("after_rsv", 32'h00000010, 32'h00000001, 5'd1,  32'h0000000F);

        // Reset during an in-flight operation discards it
        @(negedge clk);
        a  = 32'h00000001;
        b  = 32'h00000001;
        op = 5'd0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("midflight_reset", result, 32'd0);
        @(posedge clk);
        #1;
        check_eq("midflight_discard", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_reset_capture", result, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
